// File: rtl/mem_access_seq.sv
// Breaks one aligned big-endian 1/2/4/8-byte load or store into byte accesses
// on a byte-wide memory with one-cycle registered read data.
//   state | meaning
//   IDLE  | ready for a request
//   WR    | writing byte k of a store
//   RD_A  | presenting read address for byte k
//   RD_D  | read data for byte k valid, shift into accumulator
//   RSP   | one-cycle response pulse
module mem_access_seq #(
    parameter int ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [63:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_err_o,
    output logic [63:0]       rsp_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [7:0]        mem_data_in_o,
    input  logic [7:0]        mem_data_out_i
);

    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [2:0]          k_q, k_d;
    logic [63:0]         acc_q, acc_d;
    logic [63:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_write_q, mem_write_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic [2:0]          last_req;
    logic [2:0]          last_cur;
    logic [63:0]         acc_next;

    function automatic logic [2:0] last_of(input logic [1:0] sz);
        logic [2:0] r;
        case (sz)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [63:0] wd, input logic [2:0] last,
                                            input logic [2:0] k);
        logic [2:0] idx;
        idx = last - k;
        return wd[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                           input logic sg);
        logic [63:0] r;
        case (sz)
            2'd0:    r = {{56{sg & v[7]}},  v[7:0]};
            2'd1:    r = {{48{sg & v[15]}}, v[15:0]};
            2'd2:    r = {{32{sg & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign last_req = last_of(req_size_i);
    assign last_cur = last_of(size_q);
    assign acc_next = {acc_q[55:0], mem_data_out_i};

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        k_d         = k_q;
        acc_d       = acc_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = 1'b0;
        mem_data_d  = mem_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    k_d      = 3'd0;
                    acc_d    = 64'd0;
                    if ((req_addr_i[2:0] & last_req) != 3'd0) begin
                        err_d   = 1'b1;
                        state_d = RSP;
                    end else if (req_write_i) begin
                        err_d       = 1'b0;
                        state_d     = WR;
                        mem_addr_d  = req_addr_i;
                        mem_write_d = 1'b1;
                        mem_data_d  = byte_sel(req_wdata_i, last_req, 3'd0);
                    end else begin
                        err_d      = 1'b0;
                        state_d    = RD_A;
                        mem_addr_d = req_addr_i;
                    end
                end
            end
            WR: begin
                if (k_q == last_cur) begin
                    state_d = RSP;
                end else begin
                    k_d         = k_q + 3'd1;
                    mem_addr_d  = addr_q + ADDR_W'(k_d);
                    mem_write_d = 1'b1;
                    mem_data_d  = byte_sel(wdata_q, last_cur, k_d);
                end
            end
            RD_A: begin
                state_d = RD_D;
            end
            RD_D: begin
                acc_d = acc_next;
                if (k_q == last_cur) begin
                    // Result is published on entry to RSP so it is valid alongside rsp_valid.
                    rdata_d = extend(acc_next, size_q, signed_q);
                    state_d = RSP;
                end else begin
                    k_d        = k_q + 3'd1;
                    mem_addr_d = addr_q + ADDR_W'(k_d);
                    state_d    = RD_A;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 64'd0;
            k_q         <= 3'd0;
            acc_q       <= 64'd0;
            rdata_q     <= 64'd0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign rsp_valid_o   = (state_q == RSP);
    assign rsp_err_o     = (state_q == RSP) && err_q;
    assign rsp_rdata_o   = rdata_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_write_o   = mem_write_q;
    assign mem_data_in_o = mem_data_q;

endmodule
